// File: rtl/scan_session_ctrl.sv
// Scan session sequencer: gates the DUT clock, drives one scan-shifter run with
// a completion timeout, and returns a status response to the command source.
module scan_session_ctrl #(
  parameter int unsigned LEN_W        = 16,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned TMO_W        = 24
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [LEN_W-1:0] req_length,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [1:0]       resp_status,
  output logic             scan_start,
  output logic [LEN_W-1:0] scan_length,
  input  logic             scan_done,
  output logic             dut_clk_en,
  output logic             busy
);

  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_BAD_OP  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_START,
    S_WAIT,
    S_POST,
    S_RESP
  } state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    drain_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_inc;
  logic [1:0]       op;
  logic             hold;
  logic             hs;
  logic             drain_last;
  logic             tmo_hit;

  assign hs         = req_valid & req_ready;
  assign drain_last = (drain_cnt == DW'(DRAIN_CYCLES - 1));
  assign tmo_inc    = tmo_cnt + TMO_W'(1);
  assign tmo_hit    = (tmo_inc == '1);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (hs) begin
          case (req_op)
            2'd2, 2'd3: state_nxt = S_RESP;
            default:    state_nxt = hold ? S_START : S_DRAIN;
          endcase
        end
      end
      S_DRAIN: if (drain_last) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (scan_done || tmo_hit) state_nxt = S_POST;
      S_POST:  state_nxt = S_RESP;
      S_RESP:  if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake/strobe outputs are registered from the next state so every
  // output is a flop while still lining up with the state it belongs to.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      scan_start  <= 1'b0;
      resp_valid  <= 1'b0;
      resp_status <= ST_OK;
      scan_length <= '0;
      dut_clk_en  <= 1'b1;
      hold        <= 1'b0;
      op          <= '0;
      drain_cnt   <= '0;
      tmo_cnt     <= '0;
    end else begin
      req_ready  <= (state_nxt == S_IDLE);
      busy       <= (state_nxt != S_IDLE);
      scan_start <= (state_nxt == S_START);
      resp_valid <= (state_nxt == S_RESP);
      case (state)
        S_IDLE: begin
          if (hs) begin
            op        <= req_op;
            drain_cnt <= '0;
            case (req_op)
              2'd2: begin
                resp_status <= ST_OK;
                dut_clk_en  <= 1'b1;
                hold        <= 1'b0;
              end
              2'd3: resp_status <= ST_BAD_OP;
              default: begin
                scan_length <= req_length;
                dut_clk_en  <= 1'b0;
              end
            endcase
          end
        end
        S_DRAIN: drain_cnt <= drain_cnt + DW'(1);
        S_START: tmo_cnt <= '0;
        S_WAIT: begin
          // The post-scan clock decision is registered on WAIT exit so the
          // DUT clock is already running during the POST cycle.
          if (scan_done) begin
            resp_status <= ST_OK;
            if (op == 2'd0) begin
              dut_clk_en <= 1'b1;
              hold       <= 1'b0;
            end else begin
              hold <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_inc;
            if (tmo_hit) begin
              resp_status <= ST_TIMEOUT;
              hold        <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
